// File: rtl/axi4_lite_csr_pkg.sv
// ============================================================================
// Module  : axi4_lite_csr_pkg
// Purpose : Shared response encodings for the AXI4-Lite CSR slave.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package axi4_lite_csr_pkg;
  typedef logic [1:0] axi4_lite_resp_t;

  localparam axi4_lite_resp_t RESP_OKAY   = 2'b00;
  localparam axi4_lite_resp_t RESP_SLVERR = 2'b10;
endpackage

`default_nettype wire

// File: rtl/axi4_lite_if.sv
// ============================================================================
// Module  : axi4_lite_if
// Purpose : AXI4-Lite channel bundle with master and slave views.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface axi4_lite_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

`default_nettype wire

// File: rtl/axi4_lite_csr_addr_dec.sv
// ============================================================================
// Module  : axi4_lite_csr_addr_dec
// Purpose : Byte address -> word index and CR/SR/range classification.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module axi4_lite_csr_addr_dec
  import axi4_lite_csr_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int          CR_CNT     = 8,
  parameter int          SR_CNT     = 8,
  parameter int          IDX_W      = 4
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [IDX_W-1:0]      o_idx,
  output logic                  o_is_cr,
  output logic                  o_is_sr,
  output logic                  o_in_range
);
  localparam int SHIFT = $clog2(DATA_WIDTH / 8);

  logic [ADDR_WIDTH-1:0] w_off;
  logic [ADDR_WIDTH-1:0] w_word;

  assign w_off      = i_addr - ADDR_WIDTH'(BASE_ADDR);
  assign w_word     = w_off >> SHIFT;
  assign o_in_range = (i_addr >= ADDR_WIDTH'(BASE_ADDR)) &&
                      (w_word < ADDR_WIDTH'(CR_CNT + SR_CNT));
  assign o_idx      = w_word[IDX_W-1:0];
  assign o_is_cr    = o_in_range && (w_word < ADDR_WIDTH'(CR_CNT));
  assign o_is_sr    = o_in_range && !o_is_cr;
endmodule

`default_nettype wire

// File: rtl/axi4_lite_csr_slave.sv
// ============================================================================
// Module  : axi4_lite_csr_slave
// Purpose : AXI4-Lite CSR file: CR_CNT control words then SR_CNT status words.
//           Define AXI4_LITE_CSR_SLVERR_EN for SLVERR on bad writes/reads.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module axi4_lite_csr_slave
  import axi4_lite_csr_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 32,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int          CR_CNT     = 8,
  parameter int          SR_CNT     = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  axi4_lite_if.slave                         axi4_lite_i,
  output logic [CR_CNT-1:0][DATA_WIDTH-1:0]  cr_o,
  output logic [CR_CNT-1:0]                  cr_wr_stb_o,
  input  logic [SR_CNT-1:0][DATA_WIDTH-1:0]  sr_i,
  output logic [SR_CNT-1:0]                  sr_rd_stb_o
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int TOTAL  = CR_CNT + SR_CNT;
  localparam int IDX_W  = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  logic                              r_aw_held, r_w_held, r_bvalid, r_rvalid;
  logic [ADDR_WIDTH-1:0]             r_aw_addr;
  logic [DATA_WIDTH-1:0]             r_w_data, r_rdata;
  logic [STRB_W-1:0]                 r_w_strb;
  axi4_lite_resp_t                   r_bresp, r_rresp;
  logic [CR_CNT-1:0][DATA_WIDTH-1:0] r_cr;
  logic [CR_CNT-1:0]                 r_cr_stb;
  logic [SR_CNT-1:0]                 r_sr_stb;

  logic                  w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata, w_rdata;
  logic [STRB_W-1:0]     w_wstrb;
  logic [IDX_W-1:0]      w_widx, w_ridx;
  logic                  w_w_is_cr, w_w_is_sr, w_w_in_range;
  logic                  w_r_is_cr, w_r_is_sr, w_r_in_range;
  logic [SR_CNT-1:0]     w_sr_hit;
  axi4_lite_resp_t       w_wr_resp, w_rd_resp;
  logic                  w_unused;

  assign axi4_lite_i.awready = !r_aw_held && !r_bvalid;
  assign axi4_lite_i.wready  = !r_w_held && !r_bvalid;
  assign axi4_lite_i.bvalid  = r_bvalid;
  assign axi4_lite_i.bresp   = r_bresp;
  assign axi4_lite_i.arready = !r_rvalid;
  assign axi4_lite_i.rvalid  = r_rvalid;
  assign axi4_lite_i.rdata   = r_rdata;
  assign axi4_lite_i.rresp   = r_rresp;
  assign cr_o                = r_cr;
  assign cr_wr_stb_o         = r_cr_stb;
  assign sr_rd_stb_o         = r_sr_stb;

  assign w_aw_hs  = axi4_lite_i.awvalid && axi4_lite_i.awready;
  assign w_w_hs   = axi4_lite_i.wvalid && axi4_lite_i.wready;
  assign w_ar_hs  = axi4_lite_i.arvalid && axi4_lite_i.arready;
  assign w_commit = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
  // A held beat takes priority; otherwise the beat on the bus this cycle is used.
  assign w_waddr  = r_aw_held ? r_aw_addr : axi4_lite_i.awaddr;
  assign w_wdata  = r_w_held  ? r_w_data  : axi4_lite_i.wdata;
  assign w_wstrb  = r_w_held  ? r_w_strb  : axi4_lite_i.wstrb;

  axi4_lite_csr_addr_dec #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .BASE_ADDR(BASE_ADDR),
    .CR_CNT(CR_CNT), .SR_CNT(SR_CNT), .IDX_W(IDX_W)
  ) u_wr_dec (
    .i_addr(w_waddr), .o_idx(w_widx), .o_is_cr(w_w_is_cr),
    .o_is_sr(w_w_is_sr), .o_in_range(w_w_in_range)
  );

  axi4_lite_csr_addr_dec #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .BASE_ADDR(BASE_ADDR),
    .CR_CNT(CR_CNT), .SR_CNT(SR_CNT), .IDX_W(IDX_W)
  ) u_rd_dec (
    .i_addr(axi4_lite_i.araddr), .o_idx(w_ridx), .o_is_cr(w_r_is_cr),
    .o_is_sr(w_r_is_sr), .o_in_range(w_r_in_range)
  );

`ifdef AXI4_LITE_CSR_SLVERR_EN
  assign w_wr_resp = w_w_is_cr    ? RESP_OKAY : RESP_SLVERR;
  assign w_rd_resp = w_r_in_range ? RESP_OKAY : RESP_SLVERR;
`else
  assign w_wr_resp = RESP_OKAY;
  assign w_rd_resp = RESP_OKAY;
`endif

  assign w_unused = ^{axi4_lite_i.awprot, axi4_lite_i.arprot,
                      w_w_is_sr, w_w_in_range, w_r_in_range};

  always_comb begin
    w_rdata  = '0;
    w_sr_hit = '0;
    for (int i = 0; i < CR_CNT; i++) begin
      if (w_r_is_cr && (w_ridx == IDX_W'(i))) w_rdata = r_cr[i];
    end
    for (int j = 0; j < SR_CNT; j++) begin
      if (w_r_is_sr && (w_ridx == IDX_W'(CR_CNT + j))) begin
        w_rdata     = sr_i[j];
        w_sr_hit[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_aw_addr <= '0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_cr      <= '0;
      r_cr_stb  <= '0;
    end else begin
      r_cr_stb <= '0;
      if (r_bvalid && axi4_lite_i.bready) r_bvalid <= 1'b0;
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_resp;
        for (int i = 0; i < CR_CNT; i++) begin
          if (w_w_is_cr && (w_widx == IDX_W'(i))) begin
            r_cr_stb[i] <= 1'b1;
            for (int b = 0; b < STRB_W; b++) begin
              if (w_wstrb[b]) r_cr[i][8*b +: 8] <= w_wdata[8*b +: 8];
            end
          end
        end
      end else begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_aw_addr <= axi4_lite_i.awaddr;
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_w_data <= axi4_lite_i.wdata;
          r_w_strb <= axi4_lite_i.wstrb;
        end
      end
    end
  end

  // Read data is captured from r_cr before any same-edge write lands.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
      r_sr_stb <= '0;
    end else begin
      r_sr_stb <= '0;
      if (r_rvalid && axi4_lite_i.rready) r_rvalid <= 1'b0;
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata;
        r_rresp  <= w_rd_resp;
        r_sr_stb <= w_sr_hit;
      end
    end
  end
endmodule

`default_nettype wire
